// File: rtl/sr_icache_if.sv
// Instruction-fetch and backing-memory signals of the sr_icache, grouped so the
// cache (slave) and its environment (master) connect through one port.
interface sr_icache_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              im_req;
    logic [31:0]       imAddr;
    logic [31:0]       imData;
    logic              im_drdy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport slave (
        input  im_req, imAddr, mem_rdata, mem_rvalid,
        output imData, im_drdy, mem_req, mem_addr
    );

    modport master (
        output im_req, imAddr, mem_rdata, mem_rvalid,
        input  imData, im_drdy, mem_req, mem_addr
    );
endinterface

// File: rtl/sr_icache.sv
// Direct-mapped read-only instruction cache; misses refill a whole line
// word-by-word from offset 0 over a one-outstanding backing-memory port.
module sr_icache #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned OFS_W  = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    sr_icache_if.slave       bus,
    input  logic             flush,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFS_W;
    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned WORDS = 1 << OFS_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RESP} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [31:0]       words [LINES*WORDS];
    logic [ADDR_W-1:0] req_addr;
    logic [OFS_W-1:0]  fill_w;
    logic [OFS_W-1:0]  fill_next;

    logic [ADDR_W-1:0] a;
    logic [TAG_W-1:0]  a_tag, r_tag;
    logic [IDX_W-1:0]  a_idx, r_idx;
    logic [OFS_W-1:0]  a_ofs, r_ofs;
    logic              accept, hit, fill_beat;

    assign a     = bus.imAddr[ADDR_W-1:0];
    assign a_tag = a[ADDR_W-1:IDX_W+OFS_W];
    assign a_idx = a[IDX_W+OFS_W-1:OFS_W];
    assign a_ofs = a[OFS_W-1:0];
    assign r_tag = req_addr[ADDR_W-1:IDX_W+OFS_W];
    assign r_idx = req_addr[IDX_W+OFS_W-1:OFS_W];
    assign r_ofs = req_addr[OFS_W-1:0];

    assign fill_next = fill_w + 1'b1;
    assign accept    = bus.im_req && (state == IDLE || bus.im_drdy);
    assign hit       = valid[a_idx] && (tags[a_idx] == a_tag);
    assign fill_beat = (state == FILL_WAIT) && bus.mem_rvalid;

    generate
        if (ADDR_W < 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^bus.imAddr[31:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fill_beat) begin
            words[{r_idx, fill_w}] <= bus.mem_rdata;
            if (fill_w == '1)
                tags[r_idx] <= r_tag;
        end
    end

    // Tag compare is done on the accepting edge from the live address, so the
    // word is registered onto imData one cycle after acceptance; LOOKUP/RESP
    // are the cycles in which that delivery (im_drdy) is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid        <= '0;
            req_addr     <= '0;
            fill_w       <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            bus.im_drdy  <= 1'b0;
            bus.imData   <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
        end else begin
            bus.im_drdy <= 1'b0;
            bus.mem_req <= 1'b0;
            if (flush)
                valid <= '0;
            case (state)
                IDLE, LOOKUP, RESP: begin
                    if (accept) begin
                        req_addr <= a;
                        if (hit) begin
                            bus.im_drdy <= 1'b1;
                            bus.imData  <= words[{a_idx, a_ofs}];
                            hit_cnt     <= hit_cnt + 1'b1;
                            state       <= LOOKUP;
                        end else begin
                            miss_cnt     <= miss_cnt + 1'b1;
                            valid[a_idx] <= 1'b0;
                            fill_w       <= '0;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {a_tag, a_idx, {OFS_W{1'b0}}};
                            state        <= FILL_REQ;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                FILL_REQ: state <= FILL_WAIT;
                FILL_WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (fill_w == '1) begin
                            // Set after the flush clear so the line in flight survives it.
                            valid[r_idx] <= 1'b1;
                            bus.im_drdy  <= 1'b1;
                            bus.imData   <= (r_ofs == fill_w) ? bus.mem_rdata
                                                              : words[{r_idx, r_ofs}];
                            state        <= RESP;
                        end else begin
                            fill_w       <= fill_next;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {r_tag, r_idx, fill_next};
                            state        <= FILL_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
